// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding, op codes, default run length.
// The LOADA/LOADB states exist only when MULT_DIV_SEQ_DIVM_EN is defined.
package mult_div_pkg;

    localparam int unsigned MD_CYCLES_DEF = 32;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_DIVM = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_WB    = 3'd3,
        S_ERR   = 3'd4
`ifdef MULT_DIV_SEQ_DIVM_EN
        ,
        S_LOADA = 3'd5,
        S_LOADB = 3'd6
`endif
    } state_t;

endpackage

// File: rtl/mult_div_seq.sv
// Control sequencer for the shared Mult/Div unit: operand load, clear, fixed-length run, Hi/Lo writeback.
// Define MULT_DIV_SEQ_DIVM_EN to enable the divm (memory operand) path via LOADA/LOADB.
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int unsigned MD_CYCLES = MD_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       divisor_zero,
    output logic       busy,
    output logic       done,
    output logic       zero_div,
    output logic       resetlocal,
    output logic       mult_div,
    output logic       mema_a,
    output logic       memb_b,
    output logic       aux_mult_a,
    output logic       aux_mult_b,
    output logic       hi_load,
    output logic       lo_load
);

    localparam logic [5:0] CNT_LAST = 6'(MD_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [5:0] cnt;
    logic [1:0] op_q;
    logic       accept;

    always_comb begin
        accept = 1'b0;
        if (state == S_IDLE && start) begin
            case (op)
                OP_MULT, OP_DIV: accept = 1'b1;
`ifdef MULT_DIV_SEQ_DIVM_EN
                OP_DIVM:         accept = 1'b1;
`endif
                default:         accept = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept)
                op_q <= op;
            if (state == S_CLR)
                cnt <= '0;
            else if (state == S_RUN)
                cnt <= cnt + 6'd1;
        end
    end

    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        done       = 1'b0;
        zero_div   = 1'b0;
        resetlocal = 1'b0;
        mult_div   = 1'b0;
        mema_a     = 1'b0;
        memb_b     = 1'b0;
        aux_mult_a = 1'b0;
        aux_mult_b = 1'b0;
        hi_load    = 1'b0;
        lo_load    = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept)
                    state_nx = (op == OP_DIVM) ? state_t'(3'd5) : S_CLR;
            end
`ifdef MULT_DIV_SEQ_DIVM_EN
            S_LOADA: begin
                aux_mult_a = 1'b1;
                state_nx   = S_LOADB;
            end
            S_LOADB: begin
                aux_mult_b = 1'b1;
                state_nx   = S_CLR;
            end
`endif
            S_CLR: begin
                resetlocal = 1'b1;
                // Only a divide can fault; a zero B operand is harmless to a multiply.
                if (op_q != OP_MULT && divisor_zero)
                    state_nx = S_ERR;
                else
                    state_nx = S_RUN;
            end
            S_RUN: begin
                if (cnt == CNT_LAST)
                    state_nx = S_WB;
            end
            S_WB: begin
                hi_load  = 1'b1;
                lo_load  = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_ERR: begin
                done     = 1'b1;
                zero_div = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase

        if (state != S_IDLE) begin
            busy = 1'b1;
            case (op_q)
                OP_MULT: begin mult_div = 1'b0; mema_a = 1'b1; memb_b = 1'b1; end
                OP_DIV:  begin mult_div = 1'b1; mema_a = 1'b1; memb_b = 1'b1; end
                OP_DIVM: begin mult_div = 1'b1; mema_a = 1'b0; memb_b = 1'b0; end
                default: begin mult_div = 1'b0; mema_a = 1'b0; memb_b = 1'b0; end
            endcase
        end

        // Outputs are quiet for the whole reset cycle, not just after the edge.
        if (reset) begin
            busy       = 1'b0;
            done       = 1'b0;
            zero_div   = 1'b0;
            resetlocal = 1'b0;
            mult_div   = 1'b0;
            mema_a     = 1'b0;
            memb_b     = 1'b0;
            aux_mult_a = 1'b0;
            aux_mult_b = 1'b0;
            hi_load    = 1'b0;
            lo_load    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: stimulus pushes expected transactions, a monitor checks every cycle.
// Honours MULT_DIV_SEQ_DIVM_EN for the expected treatment of op 10.
module tb_mult_div_seq;

    localparam int MD = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic       divisor_zero;
    logic       busy, done, zero_div, resetlocal, mult_div, mema_a, memb_b;
    logic       aux_mult_a, aux_mult_b, hi_load, lo_load;

    mult_div_seq #(.MD_CYCLES(MD)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .divisor_zero(divisor_zero),
        .busy(busy), .done(done), .zero_div(zero_div), .resetlocal(resetlocal),
        .mult_div(mult_div), .mema_a(mema_a), .memb_b(memb_b),
        .aux_mult_a(aux_mult_a), .aux_mult_b(aux_mult_b),
        .hi_load(hi_load), .lo_load(lo_load)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int       start_c;
        int       clr_c;
        int       done_c;
        bit       is_divm;
        bit       err;
        bit [2:0] sel;
    } tx_t;

    tx_t q[$];
    int  busy_until = -1;
    int  clr_cyc    = -1;
    bit  dz_clr     = 1'b0;
    int  checks     = 0;
    int  errors     = 0;

    // Reference: accepted ops and their latency from the start cycle, in plain arithmetic.
    task automatic try_start(input logic [1:0] o, input bit dz);
        bit  ok;
        bit  dv;
        tx_t t;
        start = 1'b1;
        op    = o;
        ok    = (o == 2'b00 || o == 2'b01);
        dv    = 1'b0;
`ifdef MULT_DIV_SEQ_DIVM_EN
        if (o == 2'b10) begin ok = 1'b1; dv = 1'b1; end
`endif
        if (reset || cyc <= busy_until) ok = 1'b0;
        if (ok) begin
            t.start_c = cyc;
            t.is_divm = dv;
            t.clr_c   = cyc + (dv ? 3 : 1);
            t.err     = (o != 2'b00) && dz;
            t.done_c  = t.clr_c + (t.err ? 1 : MD + 1);
            t.sel     = (o == 2'b00) ? 3'b011 : (o == 2'b01) ? 3'b111 : 3'b100;
            q.push_back(t);
            busy_until = t.done_c;
            clr_cyc    = t.clr_c;
            dz_clr     = dz;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start        = 1'b0;
        op           = 2'($urandom);
        divisor_zero = (cyc == clr_cyc) ? dz_clr : 1'($urandom);
    endtask

    task automatic wait_busy(input int until_c);
        int n;
        n = 0;
        while (cyc <= until_c && n < MD + 8) begin
            tick();
            n++;
        end
        checks++;
        if (cyc <= until_c) begin
            errors++;
            $display("FAIL wait expired cyc=%0d until=%0d", cyc, until_c);
        end
    endtask

    task automatic wait_idle();
        wait_busy(busy_until);
    endtask

    always @(negedge clk) begin
        logic [10:0] act;
        logic [10:0] exp_v;
        tx_t t;
        bit b, d;
        exp_v = '0;
        act = {busy, done, zero_div, resetlocal, mult_div, mema_a, memb_b,
               aux_mult_a, aux_mult_b, hi_load, lo_load};
        if (!reset && q.size() > 0) begin
            t = q[0];
            b = (cyc > t.start_c) && (cyc <= t.done_c);
            d = (cyc == t.done_c);
            exp_v = {b, d, d & t.err, 1'(cyc == t.clr_c),
                     (b ? t.sel : 3'b000),
                     1'(t.is_divm && cyc == t.start_c + 1),
                     1'(t.is_divm && cyc == t.start_c + 2),
                     d & ~t.err, d & ~t.err};
        end
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL outputs cyc=%0d act=%b exp=%b (busy,done,zdiv,rstl,md,ma,mb,auxa,auxb,hi,lo)",
                     cyc, act, exp_v);
        end
        if (!reset && q.size() > 0 && cyc == q[0].done_c)
            void'(q.pop_front());
    end

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        op           = 2'b00;
        divisor_zero = 1'b0;
        tick();
        try_start(2'b00, 1'b0);
        tick();
        checks++;
        if ({busy, done, zero_div, resetlocal, mult_div, mema_a, memb_b,
             aux_mult_a, aux_mult_b, hi_load, lo_load} !== 11'b0) begin
            errors++;
            $display("FAIL reset state cyc=%0d busy=%b done=%b", cyc, busy, done);
        end
        tick();
        reset = 1'b0;
        busy_until = cyc;
        tick();

        // mult with ignored starts during the run
        begin
            int s;
            int n;
            try_start(2'b00, 1'b1);
            s = cyc;
            n = 0;
            while (cyc <= busy_until && n < MD + 8) begin
                tick();
                n++;
                if (cyc == s + 5 || cyc == s + 20) try_start(2'b01, 1'b0);
            end
            checks++;
            if (cyc <= busy_until) begin
                errors++;
                $display("FAIL mult wait expired cyc=%0d", cyc);
            end
        end

        tick(); try_start(2'b10, 1'b0); wait_idle();
        tick(); try_start(2'b01, 1'b1); wait_idle();
        tick(); try_start(2'b10, 1'b1); wait_idle();
        tick(); try_start(2'b11, 1'b0); tick(); tick(); tick();
        try_start(2'b01, 1'b0); wait_idle();

        // reset in the middle of a divide, then a fresh mult
        begin
            int s;
            tick();
            try_start(2'b01, 1'b0);
            s = cyc;
            while (cyc < s + 10) tick();
            reset = 1'b1;
            q.delete();
            busy_until = cyc;
            clr_cyc = -1;
            tick();
            reset = 1'b0;
            tick();
            try_start(2'b00, 1'b0);
        end

        // start during done is ignored, the next cycle is accepted
        wait_busy(busy_until - 1);
        try_start(2'b01, 1'b0);
        tick();
        try_start(2'b01, 1'b0);
        wait_idle();

        for (int i = 0; i < 15; i++) begin
            int gap;
            int n;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            try_start(2'($urandom), ($urandom_range(0, 2) == 0));
            n = 0;
            while (cyc <= busy_until && n < 2 * MD + 16) begin
                tick();
                n++;
                if ($urandom_range(0, 7) == 0)
                    try_start(2'($urandom), ($urandom_range(0, 2) == 0));
            end
        end
        tick();
        tick();
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 SHALL have parameter MD_CYCLES, default 32: number of RUN cycles the Mult/Div units need to produce Hi/Lo.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request from Control; sampled only in IDLE.
REQ-005 SHALL have port op, input, 2: operation code; 00 mult, 01 div, 10 divm, 11 reserved.
REQ-006 SHALL have port divisor_zero, input, 1: high when the selected B operand (mux_DivmB_out) equals 0.
REQ-007 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port zero_div, output, 1: one-cycle divide-by-zero exception pulse, coincident with done.
REQ-010 SHALL have port resetlocal, output, 1: clears the Mult/Div unit internal state.
REQ-011 SHALL have port mult_div, output, 1: 0 selects MultHi/MultLo, 1 selects DivHi/DivLo.
REQ-012 SHALL have port mema_a, output, 1: 1 selects A_Out, 0 selects MemMultA_Out.
REQ-013 SHALL have port memb_b, output, 1: 1 selects B_Out, 0 selects MemMultB_Out.
REQ-014 SHALL have ports aux_mult_a and aux_mult_b, output, 1 each: load enables for MemMultA and MemMultB.
REQ-015 SHALL have ports hi_load and lo_load, output, 1 each: load enables for the Hi and Lo registers.

Function
REQ-016 SHALL implement states IDLE, LOADA, LOADB, CLR, RUN, WB and ERR.
REQ-017 IDLE SHALL accept start with op 00 or 01 by moving to CLR, and start with op 10 by moving to LOADA; start with op 11 SHALL be ignored with no busy and no done.
REQ-018 SHALL register op on accept; mult_div, mema_a and memb_b SHALL derive from the registered op, be held constant until the return to IDLE, and be 0 in IDLE.
- mult: 0/1/1; div: 1/1/1; divm: 1/0/0.
REQ-019 LOADA SHALL assert aux_mult_a for one cycle and move to LOADB; LOADB SHALL assert aux_mult_b for one cycle and move to CLR.
REQ-020 CLR SHALL assert resetlocal for one cycle and clear the 6-bit cycle counter.
- If the op is div or divm and divisor_zero is high: move to ERR.
- Otherwise: move to RUN.
REQ-021 RUN SHALL increment the counter each cycle and move to WB after exactly MD_CYCLES cycles; divisor_zero SHALL be ignored in RUN.
REQ-022 WB SHALL assert hi_load, lo_load and done for one cycle, then return to IDLE.
REQ-023 ERR SHALL assert done and zero_div for one cycle with hi_load and lo_load low, then return to IDLE; Hi and Lo SHALL keep their old values.
REQ-024 Latency from the start cycle N: mult/div done at N+MD_CYCLES+2; divm done at N+MD_CYCLES+4; a divide by zero gives done at N+2 (div) or N+4 (divm).
REQ-025 start while busy SHALL be ignored; a new start SHALL be accepted in the cycle after done, or in the same cycle done is seen by Control only if state is IDLE.

Reset
REQ-026 reset SHALL force IDLE and clear the counter and the registered op on the next edge, including when asserted mid-operation.
REQ-027 During and after reset, all outputs SHALL be 0; reset SHALL override a simultaneous start.

Configuration
REQ-028 Macro MULT_DIV_SEQ_DIVM_EN SHALL control the divm feature.
- Defined: op 10 follows the LOADA/LOADB path.
- Undefined: LOADA and LOADB are not generated, op 10 is treated as reserved (ignored), and aux_mult_a and aux_mult_b are tied to 0.

Structure
REQ-029 A shared package mult_div_pkg SHALL hold the state enum, the op code constants (OP_MULT, OP_DIV, OP_DIVM) and the MD_CYCLES default.
REQ-030 The block SHALL be a single module with no sub-module; the counter and FSM SHALL be inline.

Verification
REQ-031 mult: start at cycle 0 with op 00 -> resetlocal at 1, busy 1..34, hi_load, lo_load and done at 34, mult_div 0, mema_a and memb_b 1 throughout.
REQ-032 divm with MULT_DIV_SEQ_DIVM_EN defined: start at 0 with op 10 -> aux_mult_a at 1, aux_mult_b at 2, resetlocal at 3, done at 36, mema_a and memb_b 0.
REQ-033 div with divisor_zero=1 in the CLR cycle: start at 0 with op 01 -> done and zero_div at 2, no hi_load, busy low at 3.
REQ-034 Ignored starts: start pulses at cycles 5 and 20 during a mult -> single done at 34; op 11 start -> busy stays 0.
REQ-035 Reset mid-operation: reset at cycle 10 of a div -> cycle 11 IDLE with all outputs 0; a fresh mult started at 12 gives done at 46.
REQ-036 With MULT_DIV_SEQ_DIVM_EN undefined: op 10 start -> no busy, no aux loads, no done.
